fetch_stage: RTL and testbench

Fetch stage of the LC-3b pipeline. It drives the front of the decode interface (`de_npc`, `de_ir`, `de_v`) and consumes the stall and branch-resolution signals that come back from the decode, AGEX and MEM stages. It holds the fetch PC, issues requests to the instruction cache over a req/ready handshake that tolerates wait states, and buffers one completed fetch while the DE latch is stalled. It also squashes wrong-path fetches and redirects to the branch or trap target supplied by MEM.

---
 rtl/fetch_stage.sv | 147 ++++++++++++++
 tb/tb_fetch_stage.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// LC-3b fetch stage: holds the fetch PC, issues I-cache requests over a req/ready
// handshake, buffers one fetch while decode stalls, and squashes wrong-path fetches.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        icache_req,
  output logic [15:0] icache_addr,
  input  logic        icache_ready,
  input  logic [15:0] icache_rdata,
  input  logic        v_de_br_stall,
  input  logic        v_agex_br_stall,
  input  logic        v_mem_br_stall,
  input  logic        dep_stall,
  input  logic        mem_stall,
  input  logic        mem_redirect,
  input  logic [15:0] mem_target,
  output logic [15:0] de_npc,
  output logic [15:0] de_ir,
  output logic        de_v
);

  typedef enum logic {FETCH, HOLD} state_t;

  state_t      state_q, state_d;
  logic [15:0] fa_q, fa_d;
  logic        pending_q, pending_d;
  logic [15:0] req_addr_q, req_addr_d;
  logic        squash_q, squash_d;
  logic [15:0] hold_ir_q, hold_ir_d;
  logic [15:0] hold_npc_q, hold_npc_d;
  logic [15:0] de_ir_q, de_ir_d;
  logic [15:0] de_npc_q, de_npc_d;
  logic        de_v_q, de_v_d;

  logic        br_stall, ld_de, done, redir, accept;
  logic [15:0] fa_plus2;

  // A started request stays up until ready, regardless of later stalls.
  always_comb begin
    br_stall    = v_de_br_stall | v_agex_br_stall | v_mem_br_stall;
    ld_de       = ~dep_stall & ~mem_stall;
    redir       = mem_redirect & v_mem_br_stall;
    icache_req  = rst_n & (state_q == FETCH) & (pending_q | ~(br_stall | mem_stall));
    icache_addr = pending_q ? req_addr_q : fa_q;
    done        = icache_req & icache_ready;
    accept      = done & ~(br_stall | redir | squash_q);
    fa_plus2    = fa_q + 16'd2;
  end

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    req_addr_d = req_addr_q;
    squash_d   = squash_q;
    hold_ir_d  = hold_ir_q;
    hold_npc_d = hold_npc_q;
    de_ir_d    = de_ir_q;
    de_npc_d   = de_npc_q;
    de_v_d     = de_v_q;
    fa_d       = fa_q;

    if (done) begin
      pending_d = 1'b0;
    end else if (icache_req) begin
      pending_d  = 1'b1;
      req_addr_d = icache_addr;
    end

    // The in-flight request belongs to the old path once a redirect passes it.
    if (redir && pending_q && !done) begin
      squash_d = 1'b1;
    end else if (done) begin
      squash_d = 1'b0;
    end

    if (redir) begin
      fa_d = mem_target;
    end else if (accept) begin
      fa_d = fa_plus2;
    end

    if (ld_de) begin
      de_v_d = 1'b0;
    end

    case (state_q)
      FETCH: begin
        if (accept) begin
          if (ld_de) begin
            de_ir_d  = icache_rdata;
            de_npc_d = fa_plus2;
            de_v_d   = 1'b1;
          end else begin
            hold_ir_d  = icache_rdata;
            hold_npc_d = fa_plus2;
            state_d    = HOLD;
          end
        end
      end
      HOLD: begin
        if (redir) begin
          hold_ir_d  = 16'h0000;
          hold_npc_d = 16'h0000;
          state_d    = FETCH;
        end else if (ld_de) begin
          de_ir_d  = hold_ir_q;
          de_npc_d = hold_npc_q;
          de_v_d   = 1'b1;
          state_d  = FETCH;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      fa_q       <= RESET_PC;
      pending_q  <= 1'b0;
      req_addr_q <= 16'h0000;
      squash_q   <= 1'b0;
      hold_ir_q  <= 16'h0000;
      hold_npc_q <= 16'h0000;
      de_ir_q    <= 16'h0000;
      de_npc_q   <= 16'h0000;
      de_v_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fa_q       <= fa_d;
      pending_q  <= pending_d;
      req_addr_q <= req_addr_d;
      squash_q   <= squash_d;
      hold_ir_q  <= hold_ir_d;
      hold_npc_q <= hold_npc_d;
      de_ir_q    <= de_ir_d;
      de_npc_q   <= de_npc_d;
      de_v_q     <= de_v_d;
    end
  end

  assign de_ir  = de_ir_q;
  assign de_npc = de_npc_q;
  assign de_v   = de_v_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: queue-based reference model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        icache_req;
  logic [15:0] icache_addr;
  logic        icache_ready = 1'b0;
  logic [15:0] icache_rdata = 16'h0000;
  logic        v_de_br_stall = 1'b0, v_agex_br_stall = 1'b0, v_mem_br_stall = 1'b0;
  logic        dep_stall = 1'b0, mem_stall = 1'b0, mem_redirect = 1'b0;
  logic [15:0] mem_target = 16'h0000;
  logic [15:0] de_npc, de_ir;
  logic        de_v;

  fetch_stage #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .icache_req(icache_req), .icache_addr(icache_addr),
    .icache_ready(icache_ready), .icache_rdata(icache_rdata),
    .v_de_br_stall(v_de_br_stall), .v_agex_br_stall(v_agex_br_stall),
    .v_mem_br_stall(v_mem_br_stall), .dep_stall(dep_stall), .mem_stall(mem_stall),
    .mem_redirect(mem_redirect), .mem_target(mem_target),
    .de_npc(de_npc), .de_ir(de_ir), .de_v(de_v)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [15:0] addr; logic wrong; } out_t;
  typedef struct packed { logic [15:0] ir; logic [15:0] npc; } ent_t;

  // Reference model: next sequential PC, outstanding request, held fetch, DE latch.
  logic [15:0] m_fa;
  out_t        out_q[$];
  ent_t        hold_q[$];
  ent_t        m_de;
  logic        m_dev;
  bit          m_known = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic rn, input logic dep, input logic ms, input logic vde,
                     input logic vag, input logic vmem, input logic mr,
                     input logic [15:0] tgt, input logic rdy);
    logic br, rd, ereq, done, ld, disc, acc;
    logic [15:0] eaddr, ir;
    ent_t e;
    out_t o;
    @(negedge clk);
    rst_n = rn; dep_stall = dep; mem_stall = ms;
    v_de_br_stall = vde; v_agex_br_stall = vag; v_mem_br_stall = vmem;
    mem_redirect = mr; mem_target = tgt; icache_ready = rdy;
    #1 icache_rdata = icache_addr ^ 16'hA5A5;
    #1;
    br    = vde | vag | vmem;
    rd    = mr & vmem;
    ereq  = rn && hold_q.size() == 0 && (out_q.size() != 0 || !(br || ms));
    eaddr = (out_q.size() != 0) ? out_q[0].addr : m_fa;
    chk("model_req", {15'd0, icache_req}, {15'd0, ereq});
    if (m_known) begin
      chk("model_addr", icache_addr, eaddr);
      chk("model_de_v", {15'd0, de_v}, {15'd0, m_dev});
      chk("model_de_ir", de_ir, m_de.ir);
      chk("model_de_npc", de_npc, m_de.npc);
    end
    if (!rn) begin
      m_fa = 16'h0000;
      out_q.delete();
      hold_q.delete();
      m_de = '0;
      m_dev = 1'b0;
      m_known = 1'b1;
    end else begin
      ld   = !dep && !ms;
      done = ereq && rdy;
      acc  = 1'b0;
      ir   = eaddr ^ 16'hA5A5;
      if (done) begin
        disc = br || rd || (out_q.size() != 0 && out_q[0].wrong);
        acc  = !disc;
        out_q.delete();
      end else if (ereq && out_q.size() == 0) begin
        out_q.push_back('{addr: eaddr, wrong: 1'b0});
      end
      if (rd && !done && out_q.size() != 0) begin
        o = out_q[0];
        o.wrong = 1'b1;
        out_q[0] = o;
      end
      if (ld) m_dev = 1'b0;
      if (hold_q.size() != 0) begin
        if (rd) hold_q.delete();
        else if (ld) begin
          m_de = hold_q.pop_front();
          m_dev = 1'b1;
        end
      end else if (acc) begin
        e.ir  = ir;
        e.npc = m_fa + 16'd2;
        if (ld) begin
          m_de = e;
          m_dev = 1'b1;
        end else hold_q.push_back(e);
      end
      if (rd) m_fa = tgt;
      else if (acc) m_fa = m_fa + 16'd2;
    end
  endtask

  task automatic run(input logic rdy);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, rdy);
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
  endtask

  task automatic fetch_n(input int n);
    for (int i = 0; i < n; i++) run(1'b1);
  endtask

  initial begin
    // Sequential fetch
    do_reset();
    chk("rst_de_v", {15'd0, de_v}, 16'd0);
    chk("rst_de_ir", de_ir, 16'h0000);
    chk("rst_de_npc", de_npc, 16'h0000);
    chk("rst_req", {15'd0, icache_req}, 16'd0);
    run(1'b1);
    chk("seq_req0", {15'd0, icache_req}, 16'd1);
    chk("seq_addr0", icache_addr, 16'h0000);
    run(1'b1);
    chk("seq_addr1", icache_addr, 16'h0002);
    chk("seq_ir0", de_ir, 16'hA5A5);
    chk("seq_npc0", de_npc, 16'h0002);
    chk("seq_v0", {15'd0, de_v}, 16'd1);
    run(1'b1);
    chk("seq_addr2", icache_addr, 16'h0004);
    chk("seq_ir1", de_ir, 16'hA5A7);
    chk("seq_npc1", de_npc, 16'h0004);
    run(1'b0);
    chk("seq_ir2", de_ir, 16'hA5A1);
    chk("seq_npc2", de_npc, 16'h0006);

    // Three wait states
    do_reset();
    for (int i = 0; i < 4; i++) begin
      run(i == 3);
      chk("ws_addr", icache_addr, 16'h0000);
      chk("ws_v0", {15'd0, de_v}, 16'd0);
    end
    run(1'b0);
    chk("ws_ir", de_ir, 16'hA5A5);
    chk("ws_npc", de_npc, 16'h0002);
    chk("ws_v", {15'd0, de_v}, 16'd1);

    // Decode stall coincident with a completion
    do_reset();
    fetch_n(2);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
    chk("ds_addr", icache_addr, 16'h0004);
    run(1'b1);
    chk("ds_noreq", {15'd0, icache_req}, 16'd0);
    chk("ds_ir_kept", de_ir, 16'hA5A7);
    run(1'b1);
    chk("ds_ir", de_ir, 16'hA5A1);
    chk("ds_npc", de_npc, 16'h0006);
    chk("ds_next", icache_addr, 16'h0006);
    run(1'b0);
    chk("ds_ir_next", de_ir, 16'hA5A3);

    // Branch stall then taken redirect; then the not-taken variant
    for (int taken = 1; taken >= 0; taken--) begin
      do_reset();
      fetch_n(4);
      run(1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
      chk("br_addr_at_done", icache_addr, 16'h0008);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
      chk("br_noreq_agex", {15'd0, icache_req}, 16'd0);
      chk("br_bubble", {15'd0, de_v}, 16'd0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, taken[0], 16'h3000, 1'b1);
      chk("br_noreq_mem", {15'd0, icache_req}, 16'd0);
      run(1'b1);
      chk("br_req", {15'd0, icache_req}, 16'd1);
      chk("br_next", icache_addr, taken ? 16'h3000 : 16'h0008);
      run(1'b0);
      chk("br_ir", de_ir, taken ? 16'h95A5 : 16'hA5AD);
    end

    // Redirect while a request is pending
    do_reset();
    fetch_n(8);
    run(1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h4000, 1'b0);
    chk("rp_addr_a", icache_addr, 16'h0010);
    run(1'b0);
    chk("rp_addr_b", icache_addr, 16'h0010);
    run(1'b1);
    chk("rp_addr_c", icache_addr, 16'h0010);
    run(1'b1);
    chk("rp_next", icache_addr, 16'h4000);
    chk("rp_v", {15'd0, de_v}, 16'd0);
    run(1'b0);
    chk("rp_ir", de_ir, 16'hE5A5);
    chk("rp_npc", de_npc, 16'h4002);

    // Redirect in the same cycle as the completion
    do_reset();
    run(1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h2000, 1'b1);
    run(1'b1);
    chk("rd_next", icache_addr, 16'h2000);
    chk("rd_v", {15'd0, de_v}, 16'd0);
    run(1'b0);
    chk("rd_ir", de_ir, 16'h85A5);

    // PC wrap at the top of memory
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFE, 1'b1);
    run(1'b1);
    chk("wr_addr", icache_addr, 16'hFFFE);
    run(1'b0);
    chk("wr_wrap", icache_addr, 16'h0000);
    chk("wr_ir", de_ir, 16'h5A5B);
    chk("wr_npc", de_npc, 16'h0000);

    // MEM stall: outstanding request completes into the hold buffer
    do_reset();
    run(1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
    chk("ms_noreq", {15'd0, icache_req}, 16'd0);
    chk("ms_v", {15'd0, de_v}, 16'd0);
    run(1'b1);
    run(1'b0);
    chk("ms_ir", de_ir, 16'hA5A5);
    chk("ms_npc", de_npc, 16'h0002);
    chk("ms_next", icache_addr, 16'h0002);

    // Reset while holding a stalled fetch
    do_reset();
    run(1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
    chk("rh_req_in_rst", {15'd0, icache_req}, 16'd0);
    run(1'b0);
    chk("rh_v", {15'd0, de_v}, 16'd0);
    chk("rh_ir", de_ir, 16'h0000);
    chk("rh_npc", de_npc, 16'h0000);
    chk("rh_req", {15'd0, icache_req}, 16'd1);
    chk("rh_addr", icache_addr, 16'h0000);

    // Reset abandoning a pending request
    run(1'b1);
    run(1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    chk("rq_req_in_rst", {15'd0, icache_req}, 16'd0);
    run(1'b1);
    chk("rq_addr", icache_addr, 16'h0000);
    chk("rq_req", {15'd0, icache_req}, 16'd1);
    run(1'b0);
    chk("rq_ir", de_ir, 16'hA5A5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
